// File: rtl/debug_mmio_monitor_pkg.sv
// Shared constants and types for the debug MMIO monitor: register offsets
// inside the 8-word window, STATUS bit positions and the decoded bus request.
package debug_mmio_monitor_pkg;

  localparam logic [2:0] DBG_OFF_CH0    = 3'd0;
  localparam logic [2:0] DBG_OFF_CH1    = 3'd1;
  localparam logic [2:0] DBG_OFF_CH2    = 3'd2;
  localparam logic [2:0] DBG_OFF_CH3    = 3'd3;
  localparam logic [2:0] DBG_OFF_INSTR  = 3'd4;
  localparam logic [2:0] DBG_OFF_CYCLE  = 3'd5;
  localparam logic [2:0] DBG_OFF_STATUS = 3'd6;
  localparam logic [2:0] DBG_OFF_TERM   = 3'd7;

  localparam int DBG_ST_OVF_LSB  = 0;
  localparam int DBG_ST_FULL_LSB = 8;
  localparam int DBG_ST_HALT_BIT = 16;

  // Bus access already qualified by window hit and clock enable.
  typedef struct packed {
    logic       hit;
    logic [2:0] off;
    logic       wr;
    logic       rd;
  } dbg_req_t;

endpackage

// File: rtl/debug_mmio_monitor_fifo.sv
// Synchronous FIFO for one output channel. Pointers carry an extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
// A push into a full FIFO is accepted only if a pop frees a slot that cycle.
module debug_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Flags, accepted operations and next pointers.
  always_comb begin
    o_empty = (wr_q == rd_q);
    o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = i_clk_en & i_pop & ~o_empty;
    do_push = i_clk_en & i_push & (~o_full | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    o_rdata = mem_q[rd_q[AW-1:0]];
  end

  // Pointer state; reset flushes any queued entries.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are meaningless until the pointers cover them.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/debug_mmio_monitor.sv
// Debug MMIO monitor on the cpu data bus: per-channel STDOUT FIFOs,
// instruction/cycle counters, sticky overflow status and a terminate latch.
module debug_mmio_monitor
  import debug_mmio_monitor_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'hFFFFF8,
  parameter int                NCHAN      = 2,
  parameter int                FIFO_DEPTH = 16,
  parameter int                CNT_W      = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clk_en,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic                    i_wr,
  input  logic                    i_rd,
  input  logic [DATA_W-1:0]       i_wdata,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_rvalid,
  input  logic                    i_retire,
  output logic [NCHAN-1:0]        o_ch_valid,
  output logic [NCHAN*DATA_W-1:0] o_ch_data,
  input  logic [NCHAN-1:0]        i_ch_ready,
  output logic                    o_halt,
  output logic [DATA_W-1:0]       o_exit_code
);

  dbg_req_t          req;
  logic [NCHAN-1:0]  push, pop, full, empty, ovf_set;
  logic [NCHAN-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]  instr_q, instr_d, cycle_q, cycle_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, exit_q, exit_d, status;
  logic              rvalid_q, rvalid_d, halt_q, halt_d;

  // Window decode and per-channel push/pop/overflow qualification.
  always_comb begin
    req.hit = (i_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    req.off = i_addr[2:0];
    req.wr  = i_clk_en & i_wr & req.hit;
    req.rd  = i_clk_en & i_rd & req.hit;
    for (int c = 0; c < NCHAN; c++) begin
      push[c]    = req.wr & ~halt_q & (req.off == 3'(c));
      pop[c]     = ~empty[c] & i_ch_ready[c];
      ovf_set[c] = push[c] & full[c] & ~pop[c];
    end
  end

  generate
    for (genvar g = 0; g < NCHAN; g++) begin : g_ch
      debug_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clk_en(i_clk_en),
        .i_push  (push[g]),
        .i_pop   (pop[g]),
        .i_wdata (i_wdata),
        .o_rdata (o_ch_data[g*DATA_W +: DATA_W]),
        .o_full  (full[g]),
        .o_empty (empty[g])
      );
    end
  endgenerate

  // STATUS word as seen by a read this cycle.
  always_comb begin
    status = '0;
    status[DBG_ST_OVF_LSB  +: NCHAN] = ovf_q;
    status[DBG_ST_FULL_LSB +: NCHAN] = full;
    status[DBG_ST_HALT_BIT]          = halt_q;
  end

  // Next state for read port, overflow bits, counters and halt latch.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ovf_d    = ovf_q;
    instr_d  = instr_q;
    cycle_d  = cycle_q;
    halt_d   = halt_q;
    exit_d   = exit_q;
    if (i_clk_en) begin
      rvalid_d = req.rd;
      if (req.rd) begin
        case (req.off)
          DBG_OFF_INSTR:  rdata_d = DATA_W'(instr_q);
          DBG_OFF_CYCLE:  rdata_d = DATA_W'(cycle_q);
          DBG_OFF_STATUS: rdata_d = status;
          DBG_OFF_TERM:   rdata_d = '0;
          default:        rdata_d = '0;
        endcase
      end
      // A new overflow wins over the read-to-clear in the same cycle.
      ovf_d = (ovf_q & ~{NCHAN{req.rd && req.off == DBG_OFF_STATUS}}) | ovf_set;
      if (!halt_q) begin
        cycle_d = cycle_q + CNT_W'(1);
        if (i_retire) instr_d = instr_q + CNT_W'(1);
        if (req.wr && req.off == DBG_OFF_TERM) begin
          halt_d = 1'b1;
          exit_d = i_wdata;
        end
      end
    end
  end

  // Top-level registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= '0;
      instr_q  <= '0;
      cycle_q  <= '0;
      halt_q   <= 1'b0;
      exit_q   <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      instr_q  <= instr_d;
      cycle_q  <= cycle_d;
      halt_q   <= halt_d;
      exit_q   <= exit_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_ch_valid  = ~empty;
  assign o_halt      = halt_q;
  assign o_exit_code = exit_q;

endmodule

// File: tb/tb_debug_mmio_monitor.sv
// Scoreboard bench for debug_mmio_monitor: stimulus pushes expected channel
// data and read results; a negedge monitor pops and compares on every
// valid&ready and every o_rvalid.
module tb_debug_mmio_monitor;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clk_en = 1'b1;
  logic [23:0] i_addr = '0;
  logic        i_wr = 1'b0, i_rd = 1'b0, i_retire = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata, o_exit_code;
  logic        o_rvalid, o_halt;
  logic [1:0]  o_ch_valid;
  logic [63:0] o_ch_data;
  logic [1:0]  i_ch_ready = '0;

  int checks = 0, failures = 0;
  logic [31:0] exp_ch0[$], exp_ch1[$], exp_rd[$];
  string       exp_rd_nm[$];

  debug_mmio_monitor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_addr(i_addr),
    .i_wr(i_wr), .i_rd(i_rd), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .i_retire(i_retire), .o_ch_valid(o_ch_valid),
    .o_ch_data(o_ch_data), .i_ch_ready(i_ch_ready), .o_halt(o_halt),
    .o_exit_code(o_exit_code)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%08h with nothing expected", nm, act);
  endtask

  // Monitor: compare every handshake and read response against the queues.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_ch_valid[0] && i_ch_ready[0]) begin
          if (exp_ch0.size() == 0) unexpected("ch0_pop", o_ch_data[31:0]);
          else chk("ch0_pop", o_ch_data[31:0], exp_ch0.pop_front());
        end
        if (o_ch_valid[1] && i_ch_ready[1]) begin
          if (exp_ch1.size() == 0) unexpected("ch1_pop", o_ch_data[63:32]);
          else chk("ch1_pop", o_ch_data[63:32], exp_ch1.pop_front());
        end
        if (o_rvalid) begin
          if (exp_rd.size() == 0) unexpected("rvalid", o_rdata);
          else chk(exp_rd_nm.pop_front(), o_rdata, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    i_addr = a; i_wdata = d; i_wr = 1'b1;
    @(posedge i_clk);
    #1 i_wr = 1'b0;
  endtask

  // Issue a read; the response must have been consumed by the following negedge.
  task automatic rd(input logic [23:0] a, input logic [31:0] e, input string nm);
    i_addr = a; i_rd = 1'b1;
    exp_rd.push_back(e);
    exp_rd_nm.push_back(nm);
    @(posedge i_clk);
    #1 i_rd = 1'b0;
    @(negedge i_clk);
    #1;
    checks++;
    if (exp_rd.size() != 0) begin
      failures++;
      $display("FAIL %s_latency: got no rvalid expected rvalid 1 cycle after read", nm);
      exp_rd.delete();
      exp_rd_nm.delete();
    end
  endtask

  task automatic drain(input int c, input string nm);
    @(posedge i_clk);
    #1 i_ch_ready[c] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!o_ch_valid[c]) break;
      @(posedge i_clk);
      #1;
    end
    chk(nm, 32'(o_ch_valid[c]), 32'd0);
    i_ch_ready[c] = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_ch_valid", 32'(o_ch_valid), 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_exit", o_exit_code, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);

    // 1: CH0 push, visible next cycle, drain in order
    wr(24'hFFFFF8, 32'h41); exp_ch0.push_back(32'h41);
    chk("t1_valid", 32'(o_ch_valid[0]), 32'd1);
    chk("t1_head", o_ch_data[31:0], 32'h41);
    wr(24'hFFFFF8, 32'h42); exp_ch0.push_back(32'h42);
    drain(0, "t1_drained");

    // 2: overflow CH1 with 17 writes, read-to-clear
    for (int i = 1; i <= 17; i++) begin
      wr(24'hFFFFF9, 32'h100 + 32'(i));
      if (i <= 16) exp_ch1.push_back(32'h100 + 32'(i));
    end
    rd(24'hFFFFFE, 32'h0000_0202, "t2_status1");
    rd(24'hFFFFFE, 32'h0000_0200, "t2_status2");

    // 3: push and pop on full FIFO in the same cycle
    @(posedge i_clk);
    #1;
    i_addr = 24'hFFFFF9; i_wdata = 32'h200; i_wr = 1'b1; i_ch_ready[1] = 1'b1;
    exp_ch1.push_back(32'h200);
    @(posedge i_clk);
    #1 i_wr = 1'b0; i_ch_ready[1] = 1'b0;
    rd(24'hFFFFFE, 32'h0000_0200, "t3_status");
    drain(1, "t3_drained");
    chk("t3_ch1_left", 32'(exp_ch1.size()), 32'd0);

    // 4: counters after reset; 10 retires in 25 cycles
    do_reset();
    for (int i = 0; i < 25; i++) begin
      i_retire = (i < 10);
      @(posedge i_clk);
      #1;
    end
    i_retire = 1'b0;
    rd(24'hFFFFFC, 32'd10, "t4_instr");
    rd(24'hFFFFFD, 32'd26, "t4_cycle");

    // 5: terminate, then everything but drain and reads is frozen
    wr(24'hFFFFF8, 32'h51); exp_ch0.push_back(32'h51);
    wr(24'hFFFFF8, 32'h52); exp_ch0.push_back(32'h52);
    wr(24'hFFFFFF, 32'h2A);
    chk("t5_halt", 32'(o_halt), 32'd1);
    chk("t5_exit", o_exit_code, 32'h2A);
    wr(24'hFFFFF8, 32'h99);
    i_retire = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_retire = 1'b0;
    rd(24'hFFFFFC, 32'd10, "t5_instr_frozen");
    rd(24'hFFFFFE, 32'h0001_0000, "t5_status");
    wr(24'hFFFFFF, 32'h77);
    chk("t5_exit_sticky", o_exit_code, 32'h2A);
    drain(0, "t5_drained");
    chk("t5_ch0_left", 32'(exp_ch0.size()), 32'd0);

    // 6a: reset mid-drain flushes pending entries immediately
    do_reset();
    chk("t6_halt_cleared", 32'(o_halt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      wr(24'hFFFFF8, 32'h60 + 32'(i));
      exp_ch0.push_back(32'h60 + 32'(i));
    end
    @(posedge i_clk);
    #1 i_ch_ready[0] = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_ch_ready[0] = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("t6_rst_ch_valid", 32'(o_ch_valid), 32'd0);
    chk("t6_rst_rdata", o_rdata, 32'd0);
    chk("t6_rst_exit", o_exit_code, 32'd0);
    chk("t6_ch0_popped", 32'(exp_ch0.size()), 32'd3);
    exp_ch0.delete();
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // 6b: clock enable low blocks pushes, reads and counting
    i_clk_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_retire = 1'b1;
      if (k % 2 == 0) begin
        i_addr = 24'hFFFFF8; i_wdata = 32'h70 + 32'(k); i_wr = 1'b1; i_rd = 1'b0;
      end else begin
        i_addr = 24'hFFFFFE; i_wr = 1'b0; i_rd = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    i_wr = 1'b0; i_rd = 1'b0; i_retire = 1'b0;
    chk("t6_en0_ch_valid", 32'(o_ch_valid), 32'd0);
    i_clk_en = 1'b1;
    rd(24'hFFFFFD, 32'd0, "t6_en0_cycle");
    rd(24'hFFFFFC, 32'd0, "t6_en0_instr");

    chk("end_ch0_q", 32'(exp_ch0.size()), 32'd0);
    chk("end_ch1_q", 32'(exp_ch1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
